ddram_arb: RTL and testbench

Three-client arbiter that shares the single 8-bit-read / 16-bit-write DDRAM port module between requesters (e.g. cartridge/CD data loader, ADPCM fetch, save-state engine). Each client uses the same toggle req/ack handshake as the DDRAM port. The arbiter serialises client transactions onto the port's write and read channels, holds the read address stable, and returns the read byte per client.

---
 rtl/ddram_arb.sv | 180 ++++++++++++++++++
 tb/tb_ddram_arb.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_arb.sv
// Purpose : three-client arbiter sharing one DDRAM port (8-bit read / 16-bit write, toggle req/ack).
// Latency : one grant cycle plus the port latency; at least one idle cycle follows every transaction.
// Backpress: one transaction in flight; other pending clients wait, the granted client is frozen until its ack toggles.
//
// Ports:
//   DDRAM_CLK, reset            clock, async active-high reset
//   RR                          1 = round-robin, 0 = fixed priority (ch0 highest)
//   chN_addr/din/wr/req         client request (toggle handshake), N = 0..2
//   chN_ack, chN_dout           client ack toggle and last read byte
//   wraddr, din, we_req/we_ack  port write channel
//   rdaddr, rd_req/rd_ack, dout port read channel (dout is combinational from rdaddr)
//   busy, grant                 transaction outstanding, index of served client
module ddram_arb (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic        RR,

  input  logic [27:0] ch0_addr,
  input  logic [15:0] ch0_din,
  input  logic        ch0_wr,
  input  logic        ch0_req,
  output logic        ch0_ack,
  output logic [7:0]  ch0_dout,

  input  logic [27:0] ch1_addr,
  input  logic [15:0] ch1_din,
  input  logic        ch1_wr,
  input  logic        ch1_req,
  output logic        ch1_ack,
  output logic [7:0]  ch1_dout,

  input  logic [27:0] ch2_addr,
  input  logic [15:0] ch2_din,
  input  logic        ch2_wr,
  input  logic        ch2_req,
  output logic        ch2_ack,
  output logic [7:0]  ch2_dout,

  output logic [27:0] wraddr,
  output logic [15:0] din,
  output logic        we_req,
  input  logic        we_ack,

  output logic [27:0] rdaddr,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [7:0]  dout,

  output logic        busy,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {SYNC, IDLE, BUSY} state_t;

  state_t      state;
  logic [2:0]  ack_q;
  logic [7:0]  dout_q [3];
  logic [1:0]  rr;
  logic        cur_wr;

  logic [2:0]  req_v;
  logic [2:0]  pend;
  logic        any_pend;
  logic [1:0]  win;
  logic [1:0]  c0, c1, c2;
  logic [27:0] sel_addr;
  logic [15:0] sel_din;
  logic        sel_wr;
  logic        done;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req_v    = {ch2_req, ch1_req, ch0_req};
  assign pend     = req_v ^ ack_q;
  assign any_pend = |pend;

  assign ch0_ack  = ack_q[0];
  assign ch1_ack  = ack_q[1];
  assign ch2_ack  = ack_q[2];
  assign ch0_dout = dout_q[0];
  assign ch1_dout = dout_q[1];
  assign ch2_dout = dout_q[2];

  // Only the channel that was toggled for this transaction is watched.
  assign done = cur_wr ? (we_ack == we_req) : (rd_ack == rd_req);

  // Winner select: round-robin scans rr, rr+1, rr+2 (mod 3); fixed picks lowest index.
  always_comb begin
    c0  = rr;
    c1  = inc3(rr);
    c2  = inc3(c1);
    win = 2'd0;
    if (RR) begin
      if (pend[c0])      win = c0;
      else if (pend[c1]) win = c1;
      else               win = c2;
    end else begin
      if (pend[0])       win = 2'd0;
      else if (pend[1])  win = 2'd1;
      else               win = 2'd2;
    end
  end

  always_comb begin
    sel_addr = ch0_addr;
    sel_din  = ch0_din;
    sel_wr   = ch0_wr;
    case (win)
      2'd1: begin
        sel_addr = ch1_addr;
        sel_din  = ch1_din;
        sel_wr   = ch1_wr;
      end
      2'd2: begin
        sel_addr = ch2_addr;
        sel_din  = ch2_din;
        sel_wr   = ch2_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state     <= SYNC;
      we_req    <= 1'b0;
      rd_req    <= 1'b0;
      wraddr    <= '0;
      rdaddr    <= '0;
      din       <= '0;
      ack_q     <= '0;
      dout_q[0] <= '0;
      dout_q[1] <= '0;
      dout_q[2] <= '0;
      rr        <= 2'd0;
      grant     <= 2'd0;
      busy      <= 1'b0;
      cur_wr    <= 1'b0;
    end else begin
      case (state)
        // Realign every toggle pair so nothing outstanding across reset is replayed.
        SYNC: begin
          we_req <= we_ack;
          rd_req <= rd_ack;
          ack_q  <= req_v;
          state  <= IDLE;
        end
        IDLE: begin
          if (any_pend) begin
            grant  <= win;
            busy   <= 1'b1;
            cur_wr <= sel_wr;
            if (sel_wr) begin
              wraddr <= sel_addr;
              din    <= sel_din;
              we_req <= ~we_req;
            end else begin
              rdaddr <= sel_addr;
              rd_req <= ~rd_req;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            ack_q <= ack_q ^ (3'b001 << grant);
            if (!cur_wr) dout_q[grant] <= dout;
            rr    <= inc3(grant);
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_arb.sv
`timescale 1ns/1ps
module tb_ddram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        RR;
  logic [27:0] c_addr [3];
  logic [15:0] c_din  [3];
  logic [2:0]  c_wr;
  logic [2:0]  c_req;
  wire  [2:0]  c_ack;
  wire  [7:0]  c_dout0, c_dout1, c_dout2;

  wire  [27:0] wraddr, rdaddr;
  wire  [15:0] din;
  wire         we_req, rd_req, busy;
  wire  [1:0]  grant;
  logic        we_ack, rd_ack;
  logic [7:0]  dout;

  ddram_arb dut (
    .DDRAM_CLK(clk), .reset(reset), .RR(RR),
    .ch0_addr(c_addr[0]), .ch0_din(c_din[0]), .ch0_wr(c_wr[0]), .ch0_req(c_req[0]),
    .ch0_ack(c_ack[0]), .ch0_dout(c_dout0),
    .ch1_addr(c_addr[1]), .ch1_din(c_din[1]), .ch1_wr(c_wr[1]), .ch1_req(c_req[1]),
    .ch1_ack(c_ack[1]), .ch1_dout(c_dout1),
    .ch2_addr(c_addr[2]), .ch2_din(c_din[2]), .ch2_wr(c_wr[2]), .ch2_req(c_req[2]),
    .ch2_ack(c_ack[2]), .ch2_dout(c_dout2),
    .wraddr(wraddr), .din(din), .we_req(we_req), .we_ack(we_ack),
    .rdaddr(rdaddr), .rd_req(rd_req), .rd_ack(rd_ack), .dout(dout),
    .busy(busy), .grant(grant)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- DDRAM port model ----------------
  logic [7:0] pmem [logic [27:0]];
  logic [7:0] rmem [logic [27:0]];
  int  port_lat = 1;
  bit  lat_rand = 0;
  int  n_ws = 0, n_rs = 0;

  function automatic logic [7:0] rd_p(input logic [27:0] a);
    if (pmem.exists(a)) return pmem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rd_r(input logic [27:0] a);
    if (rmem.exists(a)) return rmem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  initial begin
    logic lw, lr;
    bit   aw, ar;
    int   cw, cr;
    we_ack = 1'b0; rd_ack = 1'b0; dout = 8'h00;
    lw = 1'b0; lr = 1'b0; aw = 0; ar = 0; cw = 0; cr = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw = 0; ar = 0;
      end else begin
        if (we_req !== lw && we_req !== we_ack) begin
          aw = 1; n_ws++;
          cw = lat_rand ? int'($urandom_range(0, 4)) : port_lat;
        end
        if (rd_req !== lr && rd_req !== rd_ack) begin
          ar = 1; n_rs++;
          cr = lat_rand ? int'($urandom_range(0, 4)) : port_lat;
        end
        if (aw) begin
          if (cw == 0) begin
            pmem[wraddr]         = din[7:0];
            pmem[wraddr + 28'd1] = din[15:8];
            we_ack = ~we_ack;
            aw = 0;
          end else cw--;
        end
        if (ar) begin
          if (cr == 0) begin
            rd_ack = ~rd_ack;
            ar = 0;
          end else cr--;
        end
      end
      lw = we_req;
      lr = rd_req;
      dout = rd_p(rdaddr);
    end
  end

  // ---------------- behavioural reference + compare ----------------
  typedef enum {P_SYNC, P_IDLE, P_BUSY} phase_e;
  phase_e      ph = P_SYNC;
  logic        m_we, m_rd, m_busy, m_wr;
  logic [27:0] m_wa, m_ra;
  logic [15:0] m_din;
  logic [2:0]  m_ack;
  logic [7:0]  m_dout [3];
  int          m_rr, m_g;
  int          glog [$];

  initial begin
    logic        s_rst, s_rr, s_wea, s_rda;
    logic [2:0]  s_req, s_wr, pend;
    logic [27:0] s_addr [3];
    logic [15:0] s_din  [3];
    int          w;
    forever begin
      @(posedge clk);
      s_rst = reset; s_rr = RR; s_wea = we_ack; s_rda = rd_ack;
      s_req = c_req; s_wr = c_wr;
      for (int i = 0; i < 3; i++) begin
        s_addr[i] = c_addr[i];
        s_din[i]  = c_din[i];
      end
      #1;
      if (s_rst) begin
        ph = P_SYNC; m_we = 0; m_rd = 0; m_busy = 0; m_wr = 0;
        m_wa = 0; m_ra = 0; m_din = 0; m_ack = 0; m_rr = 0; m_g = 0;
        for (int i = 0; i < 3; i++) m_dout[i] = 0;
      end else begin
        case (ph)
          P_SYNC: begin
            m_we = s_wea; m_rd = s_rda; m_ack = s_req; ph = P_IDLE;
          end
          P_IDLE: begin
            pend = s_req ^ m_ack;
            if (pend != 3'b000) begin
              w = -1;
              for (int k = 0; k < 3; k++) begin
                int i;
                i = s_rr ? (m_rr + k) % 3 : k;
                if (w < 0 && pend[i]) w = i;
              end
              m_g = w; m_busy = 1; m_wr = s_wr[w];
              if (m_wr) begin
                m_wa = s_addr[w]; m_din = s_din[w]; m_we = ~m_we;
              end else begin
                m_ra = s_addr[w]; m_rd = ~m_rd;
              end
              glog.push_back(int'(grant));
              ph = P_BUSY;
            end
          end
          P_BUSY: begin
            if (m_wr ? (s_wea == m_we) : (s_rda == m_rd)) begin
              if (m_wr) begin
                rmem[m_wa]         = m_din[7:0];
                rmem[m_wa + 28'd1] = m_din[15:8];
              end else m_dout[m_g] = rd_r(m_ra);
              m_ack[m_g] = ~m_ack[m_g];
              m_rr = (m_g + 1) % 3;
              m_busy = 0;
              ph = P_IDLE;
            end
          end
          default: ;
        endcase
      end
      chk("busy", busy, m_busy);
      chk("we_req", we_req, m_we);
      chk("rd_req", rd_req, m_rd);
      chk("wraddr", wraddr, m_wa);
      chk("din", din, m_din);
      chk("rdaddr", rdaddr, m_ra);
      chk("ch_ack", c_ack, m_ack);
      chk("ch0_dout", c_dout0, m_dout[0]);
      chk("ch1_dout", c_dout1, m_dout[1]);
      chk("ch2_dout", c_dout2, m_dout[2]);
      if (m_busy) chk("grant", grant, m_g);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int n, input logic wr, input logic [27:0] a, input logic [15:0] d);
    c_wr[n]   = wr;
    c_addr[n] = a;
    c_din[n]  = d;
    c_req[n]  = ~c_req[n];
  endtask

  task automatic wait_ack(input int n, input string nm);
    int t = 0;
    while (c_req[n] !== c_ack[n] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (c_req[n] !== c_ack[n]) begin
      checks++;
      $display("FAIL %s timeout: ack %0b req %0b", nm, c_ack[n], c_req[n]);
    end
  endtask

  task automatic wait_busy(input string nm);
    int t = 0;
    while (busy !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b1) begin
      checks++;
      $display("FAIL %s busy timeout", nm);
    end
  endtask

  initial begin
    int ws0, rs0, nacks;
    reset = 1'b1; RR = 1'b1; c_req = 3'b000; c_wr = 3'b000;
    for (int i = 0; i < 3; i++) begin
      c_addr[i] = '0;
      c_din[i]  = '0;
    end
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we_req", we_req, 1'b0);
    chk("rst_rdaddr", rdaddr, 28'h0);
    chk("rst_dout0", c_dout0, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single write from ch1
    port_lat = 2; ws0 = n_ws; rs0 = n_rs;
    issue(1, 1'b1, 28'h10, 16'hA55A);
    wait_ack(1, "wr1");
    chk("wr1_wraddr", wraddr, 28'h10);
    chk("wr1_din", din, 16'hA55A);
    chk("wr1_we_toggles", n_ws - ws0, 1);
    chk("wr1_rd_toggles", n_rs - rs0, 0);
    chk("wr1_we_req", we_req, 1'b1);

    // read-back, little-endian bytes
    issue(0, 1'b1, 28'h20, 16'h1234); wait_ack(0, "wr20");
    issue(0, 1'b0, 28'h20, 16'h0);    wait_ack(0, "rd20");
    chk("rb_lo", c_dout0, 8'h34);
    issue(0, 1'b0, 28'h21, 16'h0);    wait_ack(0, "rd21");
    chk("rb_hi", c_dout0, 8'h12);
    issue(2, 1'b1, 28'h30, 16'hBEEF); wait_ack(2, "wr30");

    // round robin, all three at once
    glog.delete();
    issue(0, 1'b0, 28'h20, 16'h0);
    issue(1, 1'b0, 28'h10, 16'h0);
    issue(2, 1'b1, 28'h40, 16'hC3D2);
    wait_ack(0, "rr0"); wait_ack(1, "rr1"); wait_ack(2, "rr2");
    issue(0, 1'b0, 28'h21, 16'h0);
    issue(2, 1'b0, 28'h30, 16'h0);
    wait_ack(0, "rr0b"); wait_ack(2, "rr2b");
    chk("rr_count", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("rr_g0", glog[0], 0); chk("rr_g1", glog[1], 1); chk("rr_g2", glog[2], 2);
      chk("rr_g3", glog[3], 0); chk("rr_g4", glog[4], 2);
    end
    chk("rr_dout1", c_dout1, 8'h5A);
    chk("rr_dout2", c_dout2, 8'hEF);

    // fixed priority
    RR = 1'b0; port_lat = 4; glog.delete();
    issue(2, 1'b0, 28'h31, 16'h0);
    wait_busy("fp_busy");
    issue(1, 1'b1, 28'h50, 16'h7777);
    issue(0, 1'b0, 28'h20, 16'h0);
    wait_ack(2, "fp2"); wait_ack(0, "fp0"); wait_ack(1, "fp1");
    chk("fp_count", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("fp_g0", glog[0], 2); chk("fp_g1", glog[1], 0); chk("fp_g2", glog[2], 1);
    end
    chk("fp_dout2", c_dout2, 8'hBE);
    issue(0, 1'b0, 28'h21, 16'h0); wait_ack(0, "rd21b");
    chk("rd21b", c_dout0, 8'h12);

    // back-to-back reads on ch2
    port_lat = 0; RR = 1'b1; nacks = 0;
    for (int k = 0; k < 8; k++) begin
      issue(2, 1'b0, 28'h40 + 28'(k), 16'h0);
      wait_ack(2, "b2b");
      if (c_ack[2] === c_req[2]) nacks++;
    end
    chk("b2b_acks", nacks, 8);
    chk("b2b_last", c_dout2, 8'hE2);
    chk("b2b_idle0", c_dout0, 8'h12);
    chk("b2b_idle1", c_dout1, 8'h5A);

    // reset during a slow read
    port_lat = 10;
    issue(0, 1'b0, 28'h20, 16'h0);
    wait_busy("rst_busy_wait");
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rd_req", rd_req, 1'b0);
    chk("mid_ack0", c_ack[0], 1'b0);
    chk("mid_grant", grant, 2'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("sync_rd_req", rd_req, 1'b1);
    chk("sync_we_req", we_req, 1'b1);
    chk("sync_ack0", c_ack[0], c_req[0]);
    rs0 = n_rs; ws0 = n_ws;
    repeat (15) @(negedge clk);
    chk("post_rd_quiet", n_rs - rs0, 0);
    chk("post_we_quiet", n_ws - ws0, 0);
    chk("post_ack0", c_ack[0], c_req[0]);

    // randomized traffic
    lat_rand = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 250 == 0) RR = 1'($urandom_range(0, 1));
      for (int n = 0; n < 3; n++)
        if (c_req[n] === c_ack[n] && $urandom_range(0, 3) == 0)
          issue(n, 1'($urandom_range(0, 1)), 28'h100 + 28'($urandom_range(0, 15)), 16'($urandom));
    end
    wait_ack(0, "drain0"); wait_ack(1, "drain1"); wait_ack(2, "drain2");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
